// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and pointer helpers.
// Used by sync_fifo_ctrl for the full-pointer test.
package fifo_pkg;

  localparam int AW         = 4;
  localparam int FIFO_WIDTH = 8;

  function automatic logic ptr_full(
    input logic [31:0] w,
    input logic [31:0] r,
    input int          aw
  );
    logic [31:0] m;
    m = (32'd1 << aw) - 32'd1;
    return (((w ^ r) & m) == 32'd0) && (w[aw] != r[aw]);
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Ports: wclk/wenc/waddr/wdata write side, rclk/renc/raddr/rdata read side.
module dpram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     wclk,
  input  logic                     wenc,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rclk,
  input  logic                     renc,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge wclk) begin
    if (wenc) mem[waddr] <= wdata;
  end

  // No reset: contents and rdata are undefined until written/read.
  always_ff @(posedge rclk) begin
    if (renc) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO control: pointers, count, flags, sticky errors.
// Ports: wr_en/wdata, rd_en/rdata/rvalid, status flags, count, clr_err.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 1 << AW,
  parameter int WIDTH    = FIFO_WIDTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_err,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PA = $clog2(DEPTH);
  localparam int CW = PA + 1;

  logic          wr_acc, rd_acc;
  logic [PA:0]   wptr, rptr;
  logic [PA:0]   wptr_n, rptr_n;
  logic [CW-1:0] count_n;
  logic          full_n;

  // Acceptance uses only registered flags: no read-frees-slot bypass.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign wptr_n  = wptr + {{PA{1'b0}}, wr_acc};
  assign rptr_n  = rptr + {{PA{1'b0}}, rd_acc};
  assign count_n = count + {{PA{1'b0}}, wr_acc}
                         - {{PA{1'b0}}, rd_acc};
  assign full_n  = ptr_full(32'(wptr_n), 32'(rptr_n), PA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rvalid       <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      count        <= count_n;
      full         <= full_n;
      empty        <= (count_n == '0);
      almost_full  <= (count_n >= CW'(AF_LEVEL));
      almost_empty <= (count_n <= CW'(AE_LEVEL));
      rvalid       <= rd_acc;
      // A new error in the clearing cycle wins over the clear.
      overflow     <= (overflow & ~clr_err) | (wr_en & full);
      underflow    <= (underflow & ~clr_err) | (rd_en & empty);
    end
  end

  dpram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .wclk  (clk),
    .wenc  (wr_acc),
    .waddr (wptr[PA-1:0]),
    .wdata (wdata),
    .rclk  (clk),
    .renc  (rd_acc),
    .raddr (rptr[PA-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed table, scoreboard
// model with queue, random traffic and asynchronous reset.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             rvalid, full, empty;
  logic             almost_full, almost_empty;
  logic [4:0]       count;
  logic             overflow, underflow;

  sync_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wdata        (wdata),
    .rd_en        (rd_en),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: a queue of stored words plus sticky flags.
  logic [WIDTH-1:0] q [$];
  logic             m_ovf, m_unf, m_rv;
  logic [WIDTH-1:0] m_rd;

  typedef struct {
    logic             w, r, c;
    logic [WIDTH-1:0] d;
    int               cnt;
    logic             emp, unf, rv;
    logic [WIDTH-1:0] rd;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_ae"},    32'(almost_empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_af"},    32'(almost_full), 0);
    chk({tag, "_rvalid"},32'(rvalid), 0);
    chk({tag, "_ovf"},   32'(overflow), 0);
    chk({tag, "_unf"},   32'(underflow), 0);
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("full",  32'(full),  32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("af",    32'(almost_full),  32'(n >= DEPTH - 2));
    chk("ae",    32'(almost_empty), 32'(n <= 2));
    chk("ovf",   32'(overflow),  32'(m_ovf));
    chk("unf",   32'(underflow), 32'(m_unf));
    chk("rvalid",32'(rvalid), 32'(m_rv));
    if (m_rv) chk("rdata", 32'(rdata), 32'(m_rd));
  endtask

  // One clock: drive at negedge, update model, check at next negedge.
  task automatic cyc(input logic w, input logic r,
                     input logic c, input logic [WIDTH-1:0] d);
    bit is_full, is_empty, wa, ra;
    wr_en   = w;
    rd_en   = r;
    clr_err = c;
    wdata   = d;
    is_full  = (q.size() == DEPTH);
    is_empty = (q.size() == 0);
    wa = w && !is_full;
    ra = r && !is_empty;
    m_ovf = (m_ovf && !c) || (w && is_full);
    m_unf = (m_unf && !c) || (r && is_empty);
    m_rv  = ra;
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(d);
    @(negedge clk);
    check_model();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    // Empty FIFO: simultaneous write+read, then clear/re-error cases.
    tbl[0] = '{1, 1, 0, 8'hA5, 1, 0, 1, 0, 8'h00};
    tbl[1] = '{0, 1, 0, 8'h00, 0, 1, 1, 1, 8'hA5};
    tbl[2] = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00};
    tbl[3] = '{0, 1, 1, 8'h00, 0, 1, 1, 0, 8'h00};
    tbl[4] = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00};

    model_reset();
    m_rd = '0;

    // 1: reset and idle
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);

    // 4: table-driven empty-side corner cases
    for (int i = 0; i < 5; i++) begin
      wr_en   = tbl[i].w;
      rd_en   = tbl[i].r;
      clr_err = tbl[i].c;
      wdata   = tbl[i].d;
      @(negedge clk);
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("t%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
      chk($sformatf("t%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      if (tbl[i].rv)
        chk($sformatf("t%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    model_reset();

    // 2: fill to full, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 0, 8'(i));
      if (i == 12) chk("af_before_14", 32'(almost_full), 0);
      if (i == 13) chk("af_at_14", 32'(almost_full), 1);
    end
    chk("full_16", 32'(full), 1);
    chk("count_16", 32'(count), 16);
    cyc(1, 0, 0, 8'hEE);
    chk("ovf_17th", 32'(overflow), 1);
    chk("count_17th", 32'(count), 16);
    cyc(0, 0, 1, 8'h00);

    // 3: drain in order, then underflow
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, 0, 8'h00);
      chk("drain_rv", 32'(rvalid), 1);
      chk("drain_data", 32'(rdata), 32'(i));
    end
    chk("drain_empty", 32'(empty), 1);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    chk("unf_set", 32'(underflow), 1);
    cyc(0, 0, 1, 8'h00);

    // 5: full with simultaneous write+read
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 0, 0, 8'($urandom));
    cyc(1, 1, 0, 8'h77);
    chk("fullwr_count", 32'(count), 15);
    chk("fullwr_ovf", 32'(overflow), 1);
    cyc(0, 0, 1, 8'h00);
    while (q.size() > DEPTH / 2) cyc(0, 1, 0, 8'h00);
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, 8'($urandom));
    end

    // 6: asynchronous reset mid-stream at count 7
    while (q.size() > 7) cyc(0, 1, 0, 8'h00);
    while (q.size() < 7) cyc(1, 0, 0, 8'($urandom));
    chk("pre_rst_count", 32'(count), 7);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 8'h3C);
    cyc(0, 1, 0, 8'h00);
    chk("post_rst_data", 32'(rdata), 32'h3C);
    cyc(0, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
